// File: rtl/lpc_pkg.sv
// ---------------------------------------------------------------------------
// lpc_pkg
// Shared constants for the LPC autocorrelation front end: register map,
// control/status bit positions, compute FSM state encodings and the
// default build parameters.
// No ports (package).
// ---------------------------------------------------------------------------
package lpc_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ORDER     = 10;
    localparam int DEF_MAX_FRAME = 256;

    // Frame length after reset (30 ms at 8 kHz).
    localparam logic [15:0] DEF_FRAME_LEN = 16'd240;

    // Register addresses
    localparam logic [3:0] REG_FRAME_LEN = 4'd0;
    localparam logic [3:0] REG_CTRL      = 4'd1;
    localparam logic [3:0] REG_STATUS    = 4'd2;

    // Control register bits
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLR_BIT    = 1;

    // Status register bits
    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_OVF_BIT     = 1;
    localparam int STAT_LEN_ERR_BIT = 2;
    localparam int STAT_CNT_LSB     = 8;

    // Compute FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    // Assemble the status register image.
    function automatic logic [15:0] status_word(input logic       busy,
                                                input logic       ovf,
                                                input logic       len_err,
                                                input logic [7:0] cnt);
        logic [15:0] w;
        w                   = 16'd0;
        w[STAT_BUSY_BIT]    = busy;
        w[STAT_OVF_BIT]     = ovf;
        w[STAT_LEN_ERR_BIT] = len_err;
        w[STAT_CNT_LSB+:8]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/lpc_pingpong_buf.sv
// ---------------------------------------------------------------------------
// lpc_pingpong_buf
// Two-bank sample store. One bank fills from the ingest side while the
// other is read by the MAC engine; a swap pulse exchanges their roles.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   we, waddr, wdata write port into the fill bank
//   swap            exchange fill and compute banks
//   raddr_a/_b      two read addresses into the compute bank
//   rdata_a/_b      registered read data (one cycle latency)
// ---------------------------------------------------------------------------
module lpc_pingpong_buf #(
    parameter int DATA_W    = 16,
    parameter int MAX_FRAME = 256,
    parameter int AW        = $clog2(MAX_FRAME)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              swap,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem_r [2][MAX_FRAME];
    logic              fill_bank_r;
    logic              comp_bank_s;

    assign comp_bank_s = ~fill_bank_r;

    // Bank select: reset leaves bank 0 filling and nothing held for compute.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_bank_r <= 1'b0;
        end else if (swap) begin
            fill_bank_r <= ~fill_bank_r;
        end
    end

    // Sample storage; the swapping write lands in the old fill bank.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[fill_bank_r][waddr] <= wdata;
        end
    end

    // Registered read ports on the compute bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_a <= {DATA_W{1'b0}};
            rdata_b <= {DATA_W{1'b0}};
        end else begin
            rdata_a <= mem_r[comp_bank_s][raddr_a];
            rdata_b <= mem_r[comp_bank_s][raddr_b];
        end
    end

endmodule

// File: rtl/lpc_autocorr.sv
// ---------------------------------------------------------------------------
// lpc_autocorr
// Autocorrelation front end for the LPC encoder. Frames of signed samples
// are collected into a ping-pong buffer; R[0..ORDER] is computed with one
// sequential MAC while the next frame fills and streamed out on a
// valid/ready port.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   x, v                           sample and sample strobe
//   address, read, write,
//   writedata, readdata            register port (readdata registered)
//   r_data, r_idx, r_valid,
//   r_ready, r_last                lag output stream
//   busy                           compute engine not idle
// ---------------------------------------------------------------------------
module lpc_autocorr
    import lpc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ORDER     = DEF_ORDER,
    parameter int MAX_FRAME = DEF_MAX_FRAME,
    parameter int ACC_W     = 2*DATA_W + $clog2(MAX_FRAME)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          x,
    input  logic                       v,
    input  logic [3:0]                 address,
    input  logic                       read,
    input  logic                       write,
    input  logic [15:0]                writedata,
    output logic [15:0]                readdata,
    output logic [ACC_W-1:0]           r_data,
    output logic [$clog2(ORDER+1)-1:0] r_idx,
    output logic                       r_valid,
    input  logic                       r_ready,
    output logic                       r_last,
    output logic                       busy
);

    localparam int AW = $clog2(MAX_FRAME);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(ORDER+1);
    localparam int PW = 2*DATA_W;

    // Register state
    logic [15:0]       frame_len_r;
    logic              enable_r;
    logic              overflow_r;
    logic              len_err_r;
    logic [7:0]        frame_cnt_r;
    logic [15:0]       readdata_r;

    // Ingest state
    logic [AW-1:0]     wr_ptr_r;
    logic [15:0]       cur_len_r;

    // Compute state
    logic [2:0]        state_r;
    logic [IW-1:0]     k_r;
    logic [AW-1:0]     n_r;
    logic [LW-1:0]     len_n_r;
    logic              drain_cnt_r;
    logic              v1_r;
    logic              v2_r;
    logic signed [PW-1:0]    prod_r;
    logic signed [ACC_W-1:0] acc_r;
    logic              r_valid_r;
    logic              r_last_r;
    logic              busy_r;

    // Combinational helpers
    logic              accept_s;
    logic [15:0]       eff_len_s;
    logic              frame_end_s;
    logic              swap_s;
    logic              len_ok_s;
    logic              wr_len_s;
    logic              wr_ctrl_s;
    logic              clr_s;
    logic              mac_last_s;
    logic              k_last_s;
    logic [AW-1:0]     raddr_b_s;
    logic [DATA_W-1:0] rdata_a_s;
    logic [DATA_W-1:0] rdata_b_s;
    logic [15:0]       rd_mux_s;

    assign accept_s    = enable_r & v;
    // The first sample of a frame picks up the latest programmed length.
    assign eff_len_s   = (wr_ptr_r == {AW{1'b0}}) ? frame_len_r : cur_len_r;
    assign frame_end_s = accept_s && (16'(wr_ptr_r) == (eff_len_s - 16'd1));
    assign swap_s      = frame_end_s && (state_r == ST_IDLE);
    assign len_ok_s    = (writedata >= 16'(ORDER+1)) && (writedata <= 16'(MAX_FRAME));
    assign wr_len_s    = write && (address == REG_FRAME_LEN);
    assign wr_ctrl_s   = write && (address == REG_CTRL);
    assign clr_s       = wr_ctrl_s && writedata[CTRL_CLR_BIT];
    assign mac_last_s  = (LW'(n_r) == (len_n_r - LW'(1)));
    assign k_last_s    = (k_r == IW'(ORDER));
    // n never drops below k inside MAC, so the lagged address cannot wrap.
    assign raddr_b_s   = n_r - AW'(k_r);

    lpc_pingpong_buf #(
        .DATA_W    (DATA_W),
        .MAX_FRAME (MAX_FRAME),
        .AW        (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (accept_s),
        .waddr   (wr_ptr_r),
        .wdata   (x),
        .swap    (swap_s),
        .raddr_a (n_r),
        .raddr_b (raddr_b_s),
        .rdata_a (rdata_a_s),
        .rdata_b (rdata_b_s)
    );

    // Register read multiplexer.
    always_comb begin
        rd_mux_s = 16'd0;
        case (address)
            REG_FRAME_LEN: rd_mux_s = frame_len_r;
            REG_CTRL:      rd_mux_s = {15'd0, enable_r};
            REG_STATUS:    rd_mux_s = status_word(busy_r, overflow_r, len_err_r, frame_cnt_r);
            default:       rd_mux_s = 16'd0;
        endcase
    end

    // Register file: frame length, enable, sticky errors, frame counter, readdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_len_r <= DEF_FRAME_LEN;
            enable_r    <= 1'b1;
            overflow_r  <= 1'b0;
            len_err_r   <= 1'b0;
            frame_cnt_r <= 8'd0;
            readdata_r  <= 16'd0;
        end else begin
            if (wr_len_s && len_ok_s) begin
                frame_len_r <= writedata;
            end
            if (wr_ctrl_s) begin
                enable_r <= writedata[CTRL_ENABLE_BIT];
            end
            // A new error in the same cycle as clr is kept.
            if (wr_len_s && !len_ok_s) begin
                len_err_r <= 1'b1;
            end else if (clr_s) begin
                len_err_r <= 1'b0;
            end
            if (frame_end_s && (state_r != ST_IDLE)) begin
                overflow_r <= 1'b1;
            end else if (clr_s) begin
                overflow_r <= 1'b0;
            end
            if (swap_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
            if (read) begin
                readdata_r <= rd_mux_s;
            end
        end
    end

    // Sample ingest: write pointer and the length of the frame being filled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            cur_len_r <= DEF_FRAME_LEN;
        end else if (accept_s) begin
            if (wr_ptr_r == {AW{1'b0}}) begin
                cur_len_r <= frame_len_r;
            end
            // A dropped frame also rewinds, refilling the same bank.
            wr_ptr_r <= frame_end_s ? {AW{1'b0}} : (wr_ptr_r + AW'(1));
        end
    end

    // Compute FSM with read -> product -> accumulate pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            k_r         <= {IW{1'b0}};
            n_r         <= {AW{1'b0}};
            len_n_r     <= {LW{1'b0}};
            drain_cnt_r <= 1'b0;
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            prod_r      <= {PW{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            r_valid_r   <= 1'b0;
            r_last_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // v1 marks valid read data, v2 a valid product.
            v1_r   <= (state_r == ST_MAC);
            v2_r   <= v1_r;
            prod_r <= PW'($signed(rdata_a_s)) * PW'($signed(rdata_b_s));
            if (state_r == ST_LOAD) begin
                acc_r <= {ACC_W{1'b0}};
            end else if (v2_r) begin
                acc_r <= acc_r + ACC_W'(prod_r);
            end

            case (state_r)
                ST_IDLE: begin
                    if (swap_s) begin
                        state_r <= ST_LOAD;
                        k_r     <= {IW{1'b0}};
                        len_n_r <= LW'(eff_len_s);
                        busy_r  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    n_r     <= AW'(k_r);
                    state_r <= ST_MAC;
                end
                ST_MAC: begin
                    n_r <= n_r + AW'(1);
                    if (mac_last_s) begin
                        drain_cnt_r <= 1'b0;
                        state_r     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r) begin
                        state_r   <= ST_OUT;
                        r_valid_r <= 1'b1;
                        r_last_r  <= k_last_s;
                    end else begin
                        drain_cnt_r <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (r_ready) begin
                        r_valid_r <= 1'b0;
                        r_last_r  <= 1'b0;
                        if (k_last_s) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            k_r     <= k_r + IW'(1);
                            state_r <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    r_valid_r <= 1'b0;
                    r_last_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // acc holds still in OUT, so it doubles as the output data register.
    assign r_data   = acc_r;
    assign r_idx    = k_r;
    assign r_valid  = r_valid_r;
    assign r_last   = r_last_r;
    assign busy     = busy_r;
    assign readdata = readdata_r;

endmodule

// File: tb/tb_lpc_autocorr.sv
module tb_lpc_autocorr;

    localparam int DATA_W    = 16;
    localparam int ORDER     = 2;
    localparam int MAX_FRAME = 256;
    localparam int ACC_W     = 40;
    localparam int IW        = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] x = '0;
    logic              v = 1'b0;
    logic [3:0]        address = '0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [15:0]       writedata = '0;
    logic [15:0]       readdata;
    logic [ACC_W-1:0]  r_data;
    logic [IW-1:0]     r_idx;
    logic              r_valid;
    logic              r_ready = 1'b1;
    logic              r_last;
    logic              busy;

    lpc_autocorr #(
        .DATA_W    (DATA_W),
        .ORDER     (ORDER),
        .MAX_FRAME (MAX_FRAME),
        .ACC_W     (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .v         (v),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .r_data    (r_data),
        .r_idx     (r_idx),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_last    (r_last),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [IW-1:0]    idx;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int frames   = 0;
    logic signed [DATA_W-1:0] smp  [MAX_FRAME];
    logic signed [DATA_W-1:0] smp2 [MAX_FRAME];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference autocorrelation of smp[0..n-1], pushed into the scoreboard.
    task automatic push_frame(input int n);
        exp_t e;
        longint s;
        for (int k = 0; k <= ORDER; k++) begin
            s = 0;
            for (int i = k; i < n; i++) s += longint'(smp[i]) * longint'(smp[i-k]);
            e.data = s[ACC_W-1:0];
            e.idx  = IW'(k);
            e.last = (k == ORDER);
            exp_q.push_back(e);
        end
    endtask

    // One clock: check any handshake at the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rst && r_valid && r_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_output observed_idx=%0d expected=none", r_idx);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("r_data", 64'(r_data), 64'(e.data));
                check_val("r_idx", 64'(r_idx), 64'(e.idx));
                check_val("r_last", 64'(r_last), 64'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [15:0] d);
        address = a; writedata = d; write = 1'b1;
        cycle();
        write = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [15:0] expv);
        address = a; read = 1'b1;
        cycle();
        read = 1'b0;
        check_val(tag, 64'(readdata), 64'(expv));
    endtask

    task automatic feed_smp(input int n);
        for (int i = 0; i < n; i++) begin
            v = 1'b1; x = smp[i];
            cycle();
        end
        v = 1'b0;
    endtask

    task automatic wait_outputs(input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            cycle();
            t++;
        end
        checks++;
        assert (t < budget) else begin
            failures++;
            $error("FAIL output_timeout observed_pending=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        int b;
        int t;
        int stall_n;
        bit released;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_r_valid", 64'(r_valid), 64'd0);
        check_val("rst_r_data", 64'(r_data), 64'd0);
        check_val("rst_r_idx", 64'(r_idx), 64'd0);
        check_val("rst_r_last", 64'(r_last), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_readdata", 64'(readdata), 64'd0);
        rst = 1'b1;
        cycle();
        check_reg("rst_frame_len", 4'd0, 16'd240);
        check_reg("rst_ctrl", 4'd1, 16'h0001);
        check_reg("rst_status", 4'd2, 16'h0000);
        check_reg("unmapped", 4'd7, 16'h0000);

        // Illegal frame lengths
        reg_write(4'd0, 16'd0);
        reg_write(4'd0, 16'd300);
        check_reg("len_err_frame_len", 4'd0, 16'd240);
        check_reg("len_err_status", 4'd2, 16'h0004);
        reg_write(4'd1, 16'h0003);
        check_reg("clr_status", 4'd2, 16'h0000);
        check_reg("clr_ctrl", 4'd1, 16'h0001);

        // Short frame 1,2,3,4 -> 30, 20, 11
        reg_write(4'd0, 16'd4);
        check_reg("frame_len_4", 4'd0, 16'd4);
        for (int i = 0; i < 4; i++) smp[i] = DATA_W'(i + 1);
        push_frame(4);
        frames++;
        feed_smp(4);
        wait_outputs(200);
        check_val("busy_after_last", 64'(busy), 64'd0);
        check_reg("status_f1", 4'd2, 16'h0100);

        // Overflow: second frame ends while the engine is busy
        reg_write(4'd0, 16'd11);
        for (int i = 0; i < 11; i++) smp[i] = DATA_W'($urandom);
        push_frame(11);
        frames++;
        feed_smp(11);
        for (int i = 0; i < 11; i++) begin
            v = 1'b1; x = DATA_W'($urandom);
            cycle();
        end
        v = 1'b0;
        wait_outputs(500);
        repeat (5) cycle();
        check_reg("status_ovf", 4'd2, {8'(frames), 8'h02});
        reg_write(4'd1, 16'h0003);
        check_reg("status_ovf_clr", 4'd2, {8'(frames), 8'h00});
        for (int i = 0; i < 11; i++) smp[i] = DATA_W'($urandom);
        push_frame(11);
        frames++;
        feed_smp(11);
        wait_outputs(500);
        check_reg("status_after_ovf", 4'd2, {8'(frames), 8'h00});

        // Full-scale negative frame, stall on output while next frame fills
        reg_write(4'd0, 16'd240);
        for (int i = 0; i < 240; i++) smp[i] = -16'sd32768;
        push_frame(240);
        frames++;
        feed_smp(240);
        for (int i = 0; i < 240; i++) smp2[i] = DATA_W'($urandom);
        r_ready = 1'b0;
        b = 0; t = 0; stall_n = 0; released = 1'b0;
        while ((b < 240 || exp_q.size() != 0) && t < 4000) begin
            v = ((t % 4) == 0) && (b < 240);
            x = (b < 240) ? smp2[b] : '0;
            cycle();
            if (v) begin
                b++;
                if (b == 240) begin
                    for (int i = 0; i < 240; i++) smp[i] = smp2[i];
                    push_frame(240);
                    frames++;
                end
            end
            if (!released && (stall_n > 0 || r_valid) && exp_q.size() != 0) begin
                check_val("stall_r_valid", 64'(r_valid), 64'd1);
                check_val("stall_r_data", 64'(r_data), 64'(exp_q[0].data));
                check_val("stall_r_idx", 64'(r_idx), 64'(exp_q[0].idx));
                stall_n++;
                if (stall_n == 50) begin
                    r_ready  = 1'b1;
                    released = 1'b1;
                end
            end
            t++;
        end
        v = 1'b0;
        r_ready = 1'b1;
        checks++;
        assert (t < 4000) else begin
            failures++;
            $error("FAIL stall_phase_timeout observed_cycles=%0d expected_below=4000", t);
        end
        repeat (3) cycle();
        check_reg("status_no_ovf", 4'd2, {8'(frames), 8'h00});

        // Reset in the middle of MAC
        for (int i = 0; i < 240; i++) smp[i] = DATA_W'($urandom);
        feed_smp(240);
        repeat (20) cycle();
        check_val("busy_mid_mac", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check_val("mid_rst_r_valid", 64'(r_valid), 64'd0);
        check_val("mid_rst_r_data", 64'(r_data), 64'd0);
        check_val("mid_rst_r_idx", 64'(r_idx), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_readdata", 64'(readdata), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        frames = 0;
        cycle();
        check_reg("post_rst_frame_len", 4'd0, 16'd240);
        for (int i = 0; i < 240; i++) smp[i] = DATA_W'($urandom);
        push_frame(240);
        frames++;
        feed_smp(240);
        wait_outputs(2000);
        check_reg("post_rst_status", 4'd2, {8'(frames), 8'h00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lpc_autocorr.md
Name: lpc_autocorr

Overview:
- Parametrised autocorrelation front end for the LPC encoder.
- Collects programmable-length frames of signed speech samples into a ping-pong buffer.
- Computes R[0..ORDER] with one sequential MAC while the next frame fills, and streams the lags out over a valid/ready port to the Levinson-Durbin stage.
- Frame length and control are set through the same 16-bit address/read/write register port used elsewhere in the encoder.

Parameters:
- DATA_W, 16, sample width (signed).
- ORDER, 10, highest lag computed (ORDER+1 outputs per frame).
- MAX_FRAME, 256, buffer depth per bank; upper limit on frame length.
- ACC_W, 2*DATA_W+clog2(MAX_FRAME), accumulator and output width (signed).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- x  in  DATA_W  signed input sample.
- v  in  1  sample strobe; one sample is accepted per clk cycle with v=1.
- address  in  4  register address.
- read  in  1  register read strobe.
- write  in  1  register write strobe.
- writedata  in  16  register write data.
- readdata  out  16  register read data, valid one cycle after read.
- r_data  out  ACC_W  autocorrelation value R[r_idx].
- r_idx  out  clog2(ORDER+1)  lag index.
- r_valid  out  1  output valid.
- r_ready  in  1  downstream ready.
- r_last  out  1  high with r_idx==ORDER.
- busy  out  1  compute engine not IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - frame_len=240, enable=1.
  - Both banks marked empty; FSM in IDLE.
  - Status and overflow cleared.
  - Reset asserted mid-frame or mid-compute discards all work.
- Register map:
  - 0: frame_len (RW). Writes outside ORDER+1..MAX_FRAME are ignored and set status.len_err. A legal write takes effect at the next frame start.
  - 1: control (RW). bit0 enable; bit1 clr (write 1 clears overflow and len_err, self-clearing).
  - 2: status (RO). bit0 busy, bit1 overflow (sticky), bit2 len_err (sticky), bits15:8 frame counter mod 256.
  - Unmapped addresses read 0.
  - readdata is registered and updates only on read.
- Ingest:
  - With enable=1 and v=1, x is written to fill_bank[wr_ptr] and wr_ptr increments.
  - With enable=0, v is ignored and wr_ptr holds.
- Frame end (sample accepted with wr_ptr==frame_len-1):
  - If FSM is IDLE: banks swap, the compute bank latches N=frame_len, FSM goes to LOAD the next cycle, wr_ptr=0, frame counter +1.
  - If FSM is not IDLE: the frame is dropped, overflow is set, and wr_ptr=0 refilling the same bank.
  - Frame end and register writes in the same cycle are both honoured.
- Compute FSM (IDLE, LOAD, MAC, DRAIN, OUT):
  - LOAD: k=0, n=k, acc=0.
  - MAC: each cycle reads buf[n] and buf[n-k] (two read ports), registers the product, and accumulates with 2-stage latency. Exits after n==N-1 is issued.
  - DRAIN: 2 cycles to flush the pipeline.
  - OUT: drives r_valid=1, r_data=acc, r_idx=k, r_last=(k==ORDER). All outputs are held stable until r_ready. On the handshake, if k==ORDER the FSM goes to IDLE, else k+1 and back to LOAD.
  - r_ready high before r_valid has no effect.
  - Lag k takes N-k+4 cycles excluding stall.
  - Worst case (N=256, ORDER=10) is about 2.8k cycles, well under one 8 kHz frame.
- Arithmetic:
  - Full-precision signed products, sign-extended into ACC_W.
  - No saturation; ACC_W guarantees no overflow for N≤MAX_FRAME.
- enable cleared mid-compute: the current frame still completes and is output.

Decomposition:
- lpc_pkg holds:
  - register address constants (REG_FRAME_LEN=0, REG_CTRL=1, REG_STATUS=2);
  - status and control bit positions;
  - FSM state enum;
  - default ORDER/DATA_W.
- One natural sub-module: lpc_pingpong_buf. It contains the 2×MAX_FRAME dual-bank storage, one write port, two read ports on the compute bank, and bank-swap logic.

Test Plan:
- Reset, write frame_len=4 (ORDER=2 build), feed samples 1,2,3,4 → outputs R0=30, R1=20, R2=11, with r_last on R2 and busy falling after the final handshake.
- Default frame_len=240, all samples −32768 → R0=257698037760 and R10=230*2^30 (exact 40-bit values), no overflow.
- Hold r_ready=0 for 50 cycles during OUT → r_valid, r_data and r_idx stay stable. The ingest of the next frame continues uninterrupted.
- Set frame_len=11 and feed samples continuously every cycle so the frame ends while busy → status.overflow=1 and that frame produces no output. Writing control.clr clears the bit; the next frame outputs normally.
- Write frame_len=0 and then 300 → both are ignored, len_err=1, frame_len readback remains 240.
- Assert rst mid-MAC → all outputs 0 immediately. After release the first full frame produces correct R values.
